ysyx_25040109_mem_arbiter: RTL and testbench

Two-master, one-slave AXI4-Lite arbiter that shares the single memory slave between the instruction fetch unit (IFU, read-only master) and the load/store unit (LSU, read/write master). It sits between the core's IFU/LSU ports and the memory model. At most one transaction is in flight at a time. The grant is held from address handshake until the response handshake completes.

---
 rtl/ysyx_25040109_mem_arbiter_if.sv | 55 +++++
 rtl/ysyx_25040109_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ysyx_25040109_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25040109_mem_arbiter_if.sv
// AXI4-Lite bundle shared by the IFU, LSU and memory-side ports
// of the memory arbiter.
interface ysyx_25040109_mem_arbiter_if #(
  parameter int AW = 32
) ();

  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready;

  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;

  logic [AW-1:0] awaddr;
  logic          awvalid;
  logic          awready;

  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready;

  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;

  modport master (
    output araddr, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready,
    output awaddr, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  araddr, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready,
    input  awaddr, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/ysyx_25040109_mem_arbiter.sv
// Shares one AXI4-Lite memory slave between IFU (read-only)
// and LSU (read/write); one transaction in flight at a time.
module ysyx_25040109_mem_arbiter #(
  parameter bit RR = 1'b1,
  parameter int AW = 32
) (
  input logic clk,
  input logic rst,
  ysyx_25040109_mem_arbiter_if.slave  ifu,
  ysyx_25040109_mem_arbiter_if.slave  lsu,
  ysyx_25040109_mem_arbiter_if.master mem
);

  typedef enum logic [1:0] {
    IDLE,
    IFU_RD,
    LSU_RD,
    LSU_WR
  } state_t;

  state_t state, state_n;
  logic   last_grant, last_n;
  logic   ar_done, ar_done_n;
  logic   aw_done, aw_done_n;
  logic   w_done, w_done_n;

  logic   lsu_req;
  logic   lsu_win;
  logic   ar_fire;
  logic   aw_fire;
  logic   w_fire;
  logic   b_ok;

  // IFU never writes; its write channel is tied off.
  logic [AW-1:0] unused_ifu_awaddr;
  logic          unused_ifu_bits;

  assign unused_ifu_awaddr = ifu.awaddr;
  assign unused_ifu_bits   = ^{ifu.awvalid, ifu.wdata,
                               ifu.wstrb, ifu.wvalid,
                               ifu.bready};

  assign ifu.awready = 1'b0;
  assign ifu.wready  = 1'b0;
  assign ifu.bresp   = 2'b00;
  assign ifu.bvalid  = 1'b0;

  assign lsu_req = lsu.arvalid | lsu.awvalid;
  assign lsu_win = lsu_req &&
                   (!ifu.arvalid || !RR || !last_grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      ar_done    <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_n;
      ar_done    <= ar_done_n;
      aw_done    <= aw_done_n;
      w_done     <= w_done_n;
    end
  end

  always_comb begin
    state_n     = state;
    last_n      = last_grant;
    ar_done_n   = ar_done;
    aw_done_n   = aw_done;
    w_done_n    = w_done;
    ar_fire     = 1'b0;
    aw_fire     = 1'b0;
    w_fire      = 1'b0;
    b_ok        = 1'b0;

    mem.araddr  = '0;
    mem.arvalid = 1'b0;
    mem.rready  = 1'b0;
    mem.awaddr  = '0;
    mem.awvalid = 1'b0;
    mem.wdata   = '0;
    mem.wstrb   = '0;
    mem.wvalid  = 1'b0;
    mem.bready  = 1'b0;

    ifu.arready = 1'b0;
    ifu.rdata   = '0;
    ifu.rresp   = '0;
    ifu.rvalid  = 1'b0;

    lsu.arready = 1'b0;
    lsu.rdata   = '0;
    lsu.rresp   = '0;
    lsu.rvalid  = 1'b0;
    lsu.awready = 1'b0;
    lsu.wready  = 1'b0;
    lsu.bresp   = '0;
    lsu.bvalid  = 1'b0;

    unique case (state)
      IDLE: begin
        ar_done_n = 1'b0;
        aw_done_n = 1'b0;
        w_done_n  = 1'b0;
        if (lsu_win) begin
          last_n  = 1'b1;
          state_n = lsu.awvalid ? LSU_WR : LSU_RD;
        end else if (ifu.arvalid) begin
          last_n  = 1'b0;
          state_n = IFU_RD;
        end
      end

      IFU_RD: begin
        mem.araddr  = ifu.araddr;
        mem.arvalid = ifu.arvalid && !ar_done;
        ifu.arready = mem.arready && !ar_done;
        ar_fire     = mem.arvalid && mem.arready;
        ifu.rdata   = mem.rdata;
        ifu.rresp   = mem.rresp;
        ifu.rvalid  = mem.rvalid;
        mem.rready  = ifu.rready;
        if (ar_fire) ar_done_n = 1'b1;
        if (mem.rvalid && mem.rready) state_n = IDLE;
      end

      LSU_RD: begin
        mem.araddr  = lsu.araddr;
        mem.arvalid = lsu.arvalid && !ar_done;
        lsu.arready = mem.arready && !ar_done;
        ar_fire     = mem.arvalid && mem.arready;
        lsu.rdata   = mem.rdata;
        lsu.rresp   = mem.rresp;
        lsu.rvalid  = mem.rvalid;
        mem.rready  = lsu.rready;
        if (ar_fire) ar_done_n = 1'b1;
        if (mem.rvalid && mem.rready) state_n = IDLE;
      end

      LSU_WR: begin
        mem.awaddr  = lsu.awaddr;
        mem.awvalid = lsu.awvalid && !aw_done;
        lsu.awready = mem.awready && !aw_done;
        aw_fire     = mem.awvalid && mem.awready;
        mem.wdata   = lsu.wdata;
        mem.wstrb   = lsu.wstrb;
        mem.wvalid  = lsu.wvalid && !w_done;
        lsu.wready  = mem.wready && !w_done;
        w_fire      = mem.wvalid && mem.wready;
        // B is only meaningful once both AW and W are through.
        b_ok        = (aw_done && w_done) ||
                      (aw_fire && w_fire);
        lsu.bresp   = mem.bresp;
        lsu.bvalid  = mem.bvalid && b_ok;
        mem.bready  = lsu.bready && b_ok;
        if (aw_fire) aw_done_n = 1'b1;
        if (w_fire)  w_done_n  = 1'b1;
        if (mem.bvalid && mem.bready) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25040109_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter; one RR=1
// instance and one fixed-priority instance.
module tb_ysyx_25040109_mem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ysyx_25040109_mem_arbiter_if #(.AW(32)) fi ();
  ysyx_25040109_mem_arbiter_if #(.AW(32)) fl ();
  ysyx_25040109_mem_arbiter_if #(.AW(32)) fm ();
  ysyx_25040109_mem_arbiter_if #(.AW(32)) gi ();
  ysyx_25040109_mem_arbiter_if #(.AW(32)) gl ();
  ysyx_25040109_mem_arbiter_if #(.AW(32)) gm ();

  ysyx_25040109_mem_arbiter #(.RR(1'b1), .AW(32)) dut (
    .clk (clk),
    .rst (rst),
    .ifu (fi),
    .lsu (fl),
    .mem (fm)
  );

  ysyx_25040109_mem_arbiter #(.RR(1'b0), .AW(32)) dut0 (
    .clk (clk),
    .rst (rst),
    .ifu (gi),
    .lsu (gl),
    .mem (gm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=done");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;

    fi.araddr = '0; fi.arvalid = 0; fi.rready = 0;
    fi.awaddr = '0; fi.awvalid = 0; fi.wdata = '0;
    fi.wstrb = '0; fi.wvalid = 0; fi.bready = 0;
    fl.araddr = '0; fl.arvalid = 0; fl.rready = 0;
    fl.awaddr = '0; fl.awvalid = 0; fl.wdata = '0;
    fl.wstrb = '0; fl.wvalid = 0; fl.bready = 0;
    fm.arready = 0; fm.rdata = '0; fm.rresp = '0;
    fm.rvalid = 0; fm.awready = 0; fm.wready = 0;
    fm.bresp = '0; fm.bvalid = 0;
    gi.araddr = '0; gi.arvalid = 0; gi.rready = 0;
    gi.awaddr = '0; gi.awvalid = 0; gi.wdata = '0;
    gi.wstrb = '0; gi.wvalid = 0; gi.bready = 0;
    gl.araddr = '0; gl.arvalid = 0; gl.rready = 0;
    gl.awaddr = '0; gl.awvalid = 0; gl.wdata = '0;
    gl.wstrb = '0; gl.wvalid = 0; gl.bready = 0;
    gm.arready = 0; gm.rdata = '0; gm.rresp = '0;
    gm.rvalid = 0; gm.awready = 0; gm.wready = 0;
    gm.bresp = '0; gm.bvalid = 0;

    // reset held while masters request
    fi.arvalid = 1; fl.awvalid = 1; fl.wvalid = 1;
    cyc(); cyc(); #1;
    chk("rst_s_arvalid", {31'd0, fm.arvalid}, 0);
    chk("rst_s_awvalid", {31'd0, fm.awvalid}, 0);
    chk("rst_s_wvalid", {31'd0, fm.wvalid}, 0);
    chk("rst_lsu_bvalid", {31'd0, fl.bvalid}, 0);
    fi.arvalid = 0; fl.awvalid = 0; fl.wvalid = 0;
    rst = 0;
    cyc();

    // IFU alone
    fi.araddr = 32'h8000_0000; fi.arvalid = 1;
    fi.rready = 1; #1;
    chk("ifu_latency", {31'd0, fm.arvalid}, 0);
    cyc(); #1;
    chk("ifu_araddr", fm.araddr, 32'h8000_0000);
    chk("ifu_s_arvalid", {31'd0, fm.arvalid}, 1);
    chk("ifu_lsu_arready", {31'd0, fl.arready}, 0);
    fm.arready = 1; #1;
    chk("ifu_arready", {31'd0, fi.arready}, 1);
    cyc(); #1;
    chk("ifu_ar_once", {31'd0, fm.arvalid}, 0);
    chk("ifu_ar_blk", {31'd0, fi.arready}, 0);
    fi.arvalid = 0; fm.arready = 0;
    cyc(); cyc();
    fm.rvalid = 1; fm.rdata = 32'h0000_0413;
    fm.rresp = 2'b00; #1;
    chk("ifu_rdata", fi.rdata, 32'h0000_0413);
    chk("ifu_rresp", {30'd0, fi.rresp}, 0);
    chk("ifu_rvalid", {31'd0, fi.rvalid}, 1);
    chk("ifu_s_rready", {31'd0, fm.rready}, 1);
    chk("ifu_lsu_rvalid", {31'd0, fl.rvalid}, 0);
    cyc(); fm.rvalid = 0; #1;
    chk("ifu_r_pulse", {31'd0, fi.rvalid}, 0);
    chk("ifu_idle", {31'd0, fm.rready}, 0);

    rst = 1; cyc(); cyc(); rst = 0;

    // RR conflict: IFU first after reset, then alternate
    fi.araddr = 32'h8000_0100; fi.arvalid = 1;
    fl.araddr = 32'h8000_0200; fl.arvalid = 1;
    fl.rready = 1; fm.arready = 1;
    cyc(); #1;
    chk("rr1_first_ifu", fm.araddr, 32'h8000_0100);
    chk("rr1_lsu_blk", {31'd0, fl.arready}, 0);
    cyc();
    fi.arvalid = 0; fm.rvalid = 1;
    fm.rdata = 32'h1111_1111; #1;
    chk("rr1_ifu_rdata", fi.rdata, 32'h1111_1111);
    chk("rr1_lsu_no_r", {31'd0, fl.rvalid}, 0);
    cyc(); fm.rvalid = 0; #1;
    chk("rr1_gap", {31'd0, fm.arvalid}, 0);
    cyc(); #1;
    chk("rr1_lsu_addr", fm.araddr, 32'h8000_0200);
    chk("rr1_lsu_arv", {31'd0, fm.arvalid}, 1);
    cyc();
    fi.arvalid = 1; fm.rvalid = 1;
    fm.rdata = 32'h2222_2222; #1;
    chk("rr1_lsu_rdata", fl.rdata, 32'h2222_2222);
    chk("rr1_ifu_arready", {31'd0, fi.arready}, 0);
    cyc(); fm.rvalid = 0;
    cyc(); #1;
    chk("rr1_alt_ifu", fm.araddr, 32'h8000_0100);
    cyc(); fi.arvalid = 0; fm.rvalid = 1;
    cyc(); fm.rvalid = 0;
    cyc(); #1;
    chk("rr1_alt_lsu", fm.araddr, 32'h8000_0200);
    chk("rr1_alt_arv", {31'd0, fm.arvalid}, 1);
    cyc(); fl.arvalid = 0; fm.rvalid = 1; #1;
    chk("rr1_lsu_rv2", {31'd0, fl.rvalid}, 1);
    cyc(); fm.rvalid = 0; fm.arready = 0;

    // LSU write, AW ready two cycles before W ready
    fl.awaddr = 32'h8000_1000; fl.awvalid = 1;
    fl.wdata = 32'hDEAD_BEEF; fl.wstrb = 4'b0011;
    fl.wvalid = 1; fl.bready = 1;
    cyc(); #1;
    chk("wr_awaddr", fm.awaddr, 32'h8000_1000);
    chk("wr_wdata", fm.wdata, 32'hDEAD_BEEF);
    chk("wr_wstrb", {28'd0, fm.wstrb}, 32'h3);
    chk("wr_no_ar", {31'd0, fm.arvalid}, 0);
    chk("wr_bready_early", {31'd0, fm.bready}, 0);
    fm.awready = 1; #1;
    chk("wr_awready", {31'd0, fl.awready}, 1);
    chk("wr_wready_0", {31'd0, fl.wready}, 0);
    cyc(); #1;
    chk("wr_aw_once", {31'd0, fm.awvalid}, 0);
    chk("wr_aw_blk", {31'd0, fl.awready}, 0);
    cyc();
    fl.awvalid = 0; fm.awready = 0; fm.wready = 1; #1;
    chk("wr_wready", {31'd0, fl.wready}, 1);
    cyc();
    fm.bvalid = 1; fm.bresp = 2'b00; #1;
    chk("wr_w_once", {31'd0, fm.wvalid}, 0);
    chk("wr_bvalid", {31'd0, fl.bvalid}, 1);
    chk("wr_bready", {31'd0, fm.bready}, 1);
    cyc();
    fm.bvalid = 0; fm.wready = 0; fl.wvalid = 0; #1;
    chk("wr_idle_bv", {31'd0, fl.bvalid}, 0);
    chk("wr_idle_br", {31'd0, fm.bready}, 0);

    // LSU read and write together: write first
    fl.araddr = 32'h8000_2000; fl.arvalid = 1;
    fl.awaddr = 32'h8000_3000; fl.awvalid = 1;
    fl.wdata = 32'h1234_5678; fl.wstrb = 4'hF;
    fl.wvalid = 1;
    cyc();
    fm.awready = 1; fm.wready = 1;
    fm.bvalid = 1; fm.bresp = 2'b10; #1;
    chk("both_aw_first", {31'd0, fm.awvalid}, 1);
    chk("both_ar_held", {31'd0, fm.arvalid}, 0);
    chk("both_same_b", {31'd0, fm.bready}, 1);
    chk("both_bresp", {30'd0, fl.bresp}, 32'h2);
    cyc();
    fl.awvalid = 0; fl.wvalid = 0; fm.awready = 0;
    fm.wready = 0; fm.bvalid = 0; fm.bresp = 0; #1;
    chk("both_gap", {31'd0, fm.arvalid}, 0);
    cyc(); #1;
    chk("both_ar_addr", fm.araddr, 32'h8000_2000);
    chk("both_ar_arv", {31'd0, fm.arvalid}, 1);
    fm.arready = 1;
    cyc();
    fl.arvalid = 0; fm.arready = 0; fm.rvalid = 1;
    fm.rdata = 32'hCAFE_F00D; #1;
    chk("both_rdata", fl.rdata, 32'hCAFE_F00D);
    cyc(); fm.rvalid = 0;

    // SLVERR to IFU, then reset during a write
    fi.araddr = 32'h8000_0400; fi.arvalid = 1;
    fm.arready = 1;
    cyc(); #1;
    chk("err_araddr", fm.araddr, 32'h8000_0400);
    cyc();
    fi.arvalid = 0; fm.arready = 0; fm.rvalid = 1;
    fm.rresp = 2'b10; fm.rdata = 32'h0; #1;
    chk("err_rresp", {30'd0, fi.rresp}, 32'h2);
    cyc(); fm.rvalid = 0; fm.rresp = 0;
    fl.awaddr = 32'h8000_5000; fl.awvalid = 1;
    fl.wvalid = 1;
    cyc(); #1;
    chk("rst_pre_aw", {31'd0, fm.awvalid}, 1);
    rst = 1;
    cyc();
    fm.awready = 1; #1;
    chk("rst_mid_aw", {31'd0, fm.awvalid}, 0);
    chk("rst_mid_w", {31'd0, fm.wvalid}, 0);
    chk("rst_mid_awr", {31'd0, fl.awready}, 0);
    fl.awvalid = 0; fl.wvalid = 0; fm.awready = 0;
    rst = 0;
    cyc();
    fi.araddr = 32'h8000_0800; fi.arvalid = 1;
    cyc(); #1;
    chk("post_rst_addr", fm.araddr, 32'h8000_0800);
    chk("post_rst_arv", {31'd0, fm.arvalid}, 1);
    fm.arready = 1;
    cyc();
    fi.arvalid = 0; fm.arready = 0; fm.rvalid = 1;
    cyc(); fm.rvalid = 0;

    // fixed priority: LSU wins while requesting
    gi.araddr = 32'h8000_0010; gi.arvalid = 1;
    gi.rready = 1;
    gl.araddr = 32'h8000_0020; gl.arvalid = 1;
    gl.rready = 1; gm.arready = 1;
    cyc(); #1;
    chk("rr0_lsu1", gm.araddr, 32'h8000_0020);
    chk("rr0_ifu_blk", {31'd0, gi.arready}, 0);
    cyc(); gm.rvalid = 1; #1;
    chk("rr0_lsu_rv", {31'd0, gl.rvalid}, 1);
    cyc(); gm.rvalid = 0;
    cyc(); #1;
    chk("rr0_lsu2", gm.araddr, 32'h8000_0020);
    cyc(); gm.rvalid = 1;
    cyc(); gm.rvalid = 0; gl.arvalid = 0;
    cyc(); #1;
    chk("rr0_ifu", gm.araddr, 32'h8000_0010);
    chk("rr0_ifu_arr", {31'd0, gi.arready}, 1);
    cyc(); gi.arvalid = 0; gm.rvalid = 1;
    cyc(); gm.rvalid = 0; gm.arready = 0;
    cyc();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
